cache_tag_store: RTL and testbench
==================================

Name: cache_tag_store

Overview:
Metadata array for the 2-way set-associative L1D, directly upstream of cache_controller.
- Holds per-set tags, valid bits, dirty bits and the LRU bit.
- On a lookup it supplies tag_loaded_set1/2, valid_set1/2 and dirty_set1/2 to the controller.
- Consumes the controller's fill (write_l1) and hit-update commands, and supplies the victim way and writeback address for write_l2.

Parameters:
TAG_W, 21, tag width (addr[31:11])
INDEX_W, 7, set index width (addr[10:4]); NUM_SETS = 2**INDEX_W = 128
OFFSET_W, 4, byte offset width (16-byte lines); TAG_W+INDEX_W+OFFSET_W must equal 32

Ports:
clk  input  1  clock, rising edge
reset  input  1  synchronous, active-high
lookup  input  1  latch addr and read its set (ld|st from core)
addr  input  32  request address
touch  input  1  hit update on latched set: LRU := other way from touch_way
touch_way  input  1  way hit (0=set1, 1=set2)
touch_dirty  input  1  with touch: set dirty bit of touch_way (store hit)
fill  input  1  install latched tag into victim way (controller write_l1 after l2_ack)
fill_dirty  input  1  dirty value for filled line (1 on write-allocate store)
tag_loaded_set1  output  TAG_W  set1 tag of latched set
tag_loaded_set2  output  TAG_W  set2 tag of latched set
valid_set1, valid_set2  output  1 each  valid bits of latched set
dirty_set1, dirty_set2  output  1 each  dirty bits of latched set
rd_valid  output  1  outputs above correspond to most recent accepted lookup
victim_way  output  1  way to replace (= LRU bit of latched set)
victim_dirty  output  1  dirty bit of victim way
wb_addr  output  32  {victim tag, latched index, OFFSET_W'b0} for L2 writeback
init_busy  output  1  invalidation sweep in progress; lookup/touch/fill ignored

Behaviour:
- Reset (sync): all outputs 0, except init_busy=1. Sweep counter := 0, latched addr := 0. Reset held any number of cycles keeps counter at 0; reset asserted mid-sweep or mid-operation restarts the sweep from set 0.
- Sweep (states INIT -> READY): after reset deasserts, one set per cycle, sets 0..127 cleared (valid=0, dirty=0, LRU=0, tags 0). init_busy falls the cycle after set 127 is written, i.e. exactly 128 cycles after reset deasserts. In INIT all commands are dropped and rd_valid stays 0.
- Lookup in READY: addr latched on the edge where lookup=1. Set outputs and rd_valid=1 are registered and valid the following cycle (1-cycle latency). They remain stable until the next accepted lookup.
- rd_valid: cleared by reset; set on the cycle after the first accepted lookup and stays 1 thereafter.
- Outputs track writes to the latched set: after touch or fill, the set outputs, victim_way, victim_dirty and wb_addr reflect the updated contents the next cycle.
- touch: writes only the latched set.
  - LRU := ~touch_way.
  - If touch_dirty=1, dirty[touch_way] := 1.
  - Tags and valid bits are unchanged.
- fill: the way written is the current victim_way (w = LRU).
  - tag[w] := latched tag; valid[w] := 1; dirty[w] := fill_dirty.
  - LRU := ~w.
  - The other way is untouched.
- fill and touch in the same cycle: fill wins; touch is ignored.
- Write plus lookup in the same cycle: the write applies to the old latched set and the new addr is latched. If the new index equals the old index, the outputs show post-write contents (write-first bypass).
- wb_addr is purely derived from the registered victim tag and the latched index. Offset bits are always 0.

Decomposition:
- Package cache_pkg:
  - TAG_W, INDEX_W, OFFSET_W, NUM_WAYS=2.
  - Field slice constants TAG_LSB=11, INDEX_LSB=4.
  - Sweep state encoding INIT/READY.
  - Shared with cache_controller.
- Sub-module cache_meta_ram: 128-entry array, one write port and one read port, registered read. Entry = {2 tags, 2 valid, 2 dirty, LRU}, 47 bits.
- Sweep FSM, latch, bypass and update logic stay in cache_tag_store.

Test Plan:
1. Reset 1 cycle, then release -> init_busy=1 for exactly 128 cycles, then 0. A lookup during the sweep leaves rd_valid=0.
2. Lookup 32'hFFFFFFFF after init -> next cycle rd_valid=1, valid_set1=valid_set2=0, victim_way=0, wb_addr=32'h000007F0.
3. fill fill_dirty=0 on that set -> tag_loaded_set1=21'h1FFFFF, valid_set1=1, dirty_set1=0, victim_way=1. Re-lookup returns the same values.
4. Lookup 32'h7FFFFFFF, fill fill_dirty=1 -> tag_loaded_set2=21'h0FFFFF, valid_set2=1, dirty_set2=1, victim_way=0. wb_addr=32'hFFFFFFF0 with victim_dirty=0.
5. touch touch_way=0 touch_dirty=1 -> dirty_set1=1, victim_way=1, victim_dirty=1, wb_addr=32'h7FFFFFF0. With touch and fill together -> only the fill takes effect.
6. Reset asserted mid-sweep at set 50 and in READY with set 0x7F populated -> sweep restarts from 0, a full 128 cycles of init_busy. A subsequent lookup of 0xFFFFFFFF shows both ways invalid.

Source files
------------

// File: rtl/cache_pkg.sv
// Shared L1D metadata definitions: address field geometry, sweep states and
// the per-set metadata entry used by the tag store and the cache controller.
package cache_pkg;

  localparam int TAG_W     = 21;
  localparam int INDEX_W   = 7;
  localparam int OFFSET_W  = 4;
  localparam int NUM_WAYS  = 2;
  localparam int NUM_SETS  = 2 ** INDEX_W;
  localparam int TAG_LSB   = 11;
  localparam int INDEX_LSB = 4;

  typedef enum logic {
    INIT,
    READY
  } sweep_state_t;

  // 47-bit entry: two tags, two valid bits, two dirty bits and the LRU bit
  typedef struct packed {
    logic [TAG_W-1:0] tag1;
    logic [TAG_W-1:0] tag2;
    logic             valid1;
    logic             valid2;
    logic             dirty1;
    logic             dirty2;
    logic             lru;
  } meta_entry_t;

  function automatic logic [31:0] make_wb_addr(input logic [TAG_W-1:0]   tag,
                                               input logic [INDEX_W-1:0] index);
    return {tag, index, {OFFSET_W{1'b0}}};
  endfunction

endpackage

// File: rtl/cache_tag_store_if.sv
// Command/response bundle between the cache controller (master) and the
// tag store (slave).
interface cache_tag_store_if;
  import cache_pkg::*;

  logic               lookup;
  logic [31:0]        addr;
  logic               touch;
  logic               touch_way;
  logic               touch_dirty;
  logic               fill;
  logic               fill_dirty;
  logic [TAG_W-1:0]   tag_loaded_set1;
  logic [TAG_W-1:0]   tag_loaded_set2;
  logic               valid_set1;
  logic               valid_set2;
  logic               dirty_set1;
  logic               dirty_set2;
  logic               rd_valid;
  logic               victim_way;
  logic               victim_dirty;
  logic [31:0]        wb_addr;
  logic               init_busy;

  modport master (
    output lookup, addr, touch, touch_way, touch_dirty, fill, fill_dirty,
    input  tag_loaded_set1, tag_loaded_set2, valid_set1, valid_set2,
           dirty_set1, dirty_set2, rd_valid, victim_way, victim_dirty,
           wb_addr, init_busy
  );

  modport slave (
    input  lookup, addr, touch, touch_way, touch_dirty, fill, fill_dirty,
    output tag_loaded_set1, tag_loaded_set2, valid_set1, valid_set2,
           dirty_set1, dirty_set2, rd_valid, victim_way, victim_dirty,
           wb_addr, init_busy
  );

endinterface

// File: rtl/cache_meta_ram.sv
// 128-entry metadata array with one write port and one registered read port.
module cache_meta_ram
  import cache_pkg::*;
(
  input  logic               clk,
  input  logic               we,
  input  logic [INDEX_W-1:0] waddr,
  input  meta_entry_t        wdata,
  input  logic [INDEX_W-1:0] raddr,
  output meta_entry_t        rdata
);

  meta_entry_t mem [NUM_SETS];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
    rdata <= mem[raddr];
  end

endmodule

// File: rtl/cache_tag_store.sv
// Tag/valid/dirty/LRU store for the 2-way L1D: invalidation sweep after reset,
// latched-set lookup, hit updates, fills and victim writeback address.
module cache_tag_store
  import cache_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  cache_tag_store_if.slave   bus
);

  sweep_state_t                      state;
  logic [INDEX_W-1:0]                sweep_cnt;
  logic [TAG_W-1:0]                  lat_tag;
  logic [INDEX_W-1:0]                lat_index;
  logic [INDEX_W-1:0]                new_index;
  meta_entry_t                       cur;
  meta_entry_t                       ram_rdata;
  meta_entry_t                       eff;
  meta_entry_t                       written;
  logic                              use_ram;
  logic                              rd_valid_q;
  logic                              ready;
  logic                              wr;
  logic [$clog2(NUM_WAYS)-1:0]       fill_way;
  logic                              ram_we;
  logic [INDEX_W-1:0]                ram_waddr;
  meta_entry_t                       ram_wdata;
  logic                              unused_offset;

  assign ready         = (state == READY);
  assign wr            = ready && (bus.fill || bus.touch);
  assign new_index     = bus.addr[INDEX_LSB +: INDEX_W];
  assign unused_offset = ^bus.addr[OFFSET_W-1:0];

  // A lookup to a new set is served straight from the RAM read register for
  // one cycle, then folded into cur; every later write works on cur.
  always_comb begin
    eff      = use_ram ? ram_rdata : cur;
    written  = eff;
    fill_way = eff.lru;
    if (bus.fill) begin
      if (fill_way == 1'b0) begin
        written.tag1   = lat_tag;
        written.valid1 = 1'b1;
        written.dirty1 = bus.fill_dirty;
      end else begin
        written.tag2   = lat_tag;
        written.valid2 = 1'b1;
        written.dirty2 = bus.fill_dirty;
      end
      written.lru = ~fill_way;
    end else if (bus.touch) begin
      written.lru = ~bus.touch_way;
      if (bus.touch_dirty) begin
        if (bus.touch_way == 1'b0) written.dirty1 = 1'b1;
        else                       written.dirty2 = 1'b1;
      end
    end
  end

  assign ram_we    = !ready || wr;
  assign ram_waddr = ready ? lat_index : sweep_cnt;
  assign ram_wdata = ready ? written : '0;

  cache_meta_ram u_meta_ram (
    .clk   (clk),
    .we    (ram_we),
    .waddr (ram_waddr),
    .wdata (ram_wdata),
    .raddr (new_index),
    .rdata (ram_rdata)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= INIT;
      sweep_cnt  <= '0;
      lat_tag    <= '0;
      lat_index  <= '0;
      cur        <= '0;
      use_ram    <= 1'b0;
      rd_valid_q <= 1'b0;
    end else if (state == INIT) begin
      sweep_cnt <= sweep_cnt + 1'b1;
      if (&sweep_cnt) begin
        state <= READY;
      end
    end else begin
      // Same-index lookup keeps the post-write contents (write-first bypass)
      if (bus.lookup) begin
        lat_tag    <= bus.addr[TAG_LSB +: TAG_W];
        lat_index  <= new_index;
        rd_valid_q <= 1'b1;
        if (new_index == lat_index) begin
          cur     <= written;
          use_ram <= 1'b0;
        end else begin
          use_ram <= 1'b1;
        end
      end else begin
        cur     <= written;
        use_ram <= 1'b0;
      end
    end
  end

  assign bus.tag_loaded_set1 = eff.tag1;
  assign bus.tag_loaded_set2 = eff.tag2;
  assign bus.valid_set1      = eff.valid1;
  assign bus.valid_set2      = eff.valid2;
  assign bus.dirty_set1      = eff.dirty1;
  assign bus.dirty_set2      = eff.dirty2;
  assign bus.rd_valid        = rd_valid_q;
  assign bus.victim_way      = eff.lru;
  assign bus.victim_dirty    = eff.lru ? eff.dirty2 : eff.dirty1;
  assign bus.wb_addr         = make_wb_addr(eff.lru ? eff.tag2 : eff.tag1, lat_index);
  assign bus.init_busy       = (state == INIT);

endmodule

// File: tb/tb_cache_tag_store.sv
// Directed, table-driven bench for cache_tag_store: sweep timing, lookups,
// fills, touches, bypass and reset restarts.
module tb_cache_tag_store;
  import cache_pkg::*;

  typedef struct {
    string       name;
    logic        lookup;
    logic [31:0] addr;
    logic        touch;
    logic        touch_way;
    logic        touch_dirty;
    logic        fill;
    logic        fill_dirty;
    logic        exp_rd_valid;
    logic [20:0] exp_tag1;
    logic [20:0] exp_tag2;
    logic        exp_valid1;
    logic        exp_valid2;
    logic        exp_dirty1;
    logic        exp_dirty2;
    logic        exp_victim_way;
    logic        exp_victim_dirty;
    logic [31:0] exp_wb_addr;
  } vec_t;

  logic clk;
  logic reset;
  int   tests_run;
  int   tests_failed;
  vec_t vecs[14];
  vec_t final_vec;

  cache_tag_store_if bus ();

  cache_tag_store dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkField(input string tname, input string field,
                            input logic [31:0] actual, input logic [31:0] expected);
    tests_run++;
    if (actual !== expected) begin
      tests_failed++;
      $display("[TB] FAIL %s.%s: got %h expected %h", tname, field, actual, expected);
    end
  endtask

  task automatic clearInputs();
    bus.lookup      = 1'b0;
    bus.addr        = 32'h0;
    bus.touch       = 1'b0;
    bus.touch_way   = 1'b0;
    bus.touch_dirty = 1'b0;
    bus.fill        = 1'b0;
    bus.fill_dirty  = 1'b0;
  endtask

  task automatic applyStimulus(input vec_t v);
    bus.lookup      = v.lookup;
    bus.addr        = v.addr;
    bus.touch       = v.touch;
    bus.touch_way   = v.touch_way;
    bus.touch_dirty = v.touch_dirty;
    bus.fill        = v.fill;
    bus.fill_dirty  = v.fill_dirty;
    @(posedge clk);
    #1;
    clearInputs();
  endtask

  task automatic checkOutput(input vec_t v);
    checkField(v.name, "rd_valid",     32'(bus.rd_valid),        32'(v.exp_rd_valid));
    checkField(v.name, "tag1",         32'(bus.tag_loaded_set1), 32'(v.exp_tag1));
    checkField(v.name, "tag2",         32'(bus.tag_loaded_set2), 32'(v.exp_tag2));
    checkField(v.name, "valid1",       32'(bus.valid_set1),      32'(v.exp_valid1));
    checkField(v.name, "valid2",       32'(bus.valid_set2),      32'(v.exp_valid2));
    checkField(v.name, "dirty1",       32'(bus.dirty_set1),      32'(v.exp_dirty1));
    checkField(v.name, "dirty2",       32'(bus.dirty_set2),      32'(v.exp_dirty2));
    checkField(v.name, "victim_way",   32'(bus.victim_way),      32'(v.exp_victim_way));
    checkField(v.name, "victim_dirty", 32'(bus.victim_dirty),    32'(v.exp_victim_dirty));
    checkField(v.name, "wb_addr",      bus.wb_addr,              v.exp_wb_addr);
    checkField(v.name, "init_busy",    32'(bus.init_busy),       32'h0);
  endtask

  task automatic doReset(input int cycles);
    reset = 1'b1;
    repeat (cycles) @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  task automatic checkResetState(input string tname);
    checkField(tname, "init_busy",  32'(bus.init_busy),       32'h1);
    checkField(tname, "rd_valid",   32'(bus.rd_valid),        32'h0);
    checkField(tname, "valid1",     32'(bus.valid_set1),      32'h0);
    checkField(tname, "tag1",       32'(bus.tag_loaded_set1), 32'h0);
    checkField(tname, "victim_way", 32'(bus.victim_way),      32'h0);
    checkField(tname, "wb_addr",    bus.wb_addr,              32'h0);
  endtask

  // Counts busy cycles after reset release; optionally pulses a lookup mid-sweep
  task automatic runSweep(input string tname, input int lookup_at);
    int n;
    n = 0;
    while (bus.init_busy === 1'b1 && n < 400) begin
      if (n == lookup_at) begin
        bus.lookup = 1'b1;
        bus.addr   = 32'hFFFF_FFFF;
      end else begin
        clearInputs();
      end
      @(posedge clk);
      #1;
      n++;
    end
    clearInputs();
    checkField(tname, "init_cycles", 32'(n), 32'd128);
    checkField(tname, "rd_valid_after_sweep", 32'(bus.rd_valid), 32'h0);
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    reset        = 1'b1;
    clearInputs();

    // name, lookup, addr, touch, tway, tdirty, fill, fdirty | rdv, tag1, tag2, v1, v2, d1, d2, vway, vdirty, wb
    vecs[0]  = '{"lookup_ff",        1'b1, 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0,
                 1'b1, 21'h000000, 21'h000000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0000_07F0};
    vecs[1]  = '{"fill_clean",       1'b0, 32'h0,         1'b0, 1'b0, 1'b0, 1'b1, 1'b0,
                 1'b1, 21'h1FFFFF, 21'h000000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0000_07F0};
    vecs[2]  = '{"relookup_ff",      1'b1, 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0,
                 1'b1, 21'h1FFFFF, 21'h000000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0000_07F0};
    vecs[3]  = '{"lookup_7f",        1'b1, 32'h7FFF_FFFF, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0,
                 1'b1, 21'h1FFFFF, 21'h000000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0000_07F0};
    vecs[4]  = '{"fill_dirty",       1'b0, 32'h0,         1'b0, 1'b0, 1'b0, 1'b1, 1'b1,
                 1'b1, 21'h1FFFFF, 21'h0FFFFF, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 32'hFFFF_FFF0};
    vecs[5]  = '{"touch_w0_dirty",   1'b0, 32'h0,         1'b1, 1'b0, 1'b1, 1'b0, 1'b0,
                 1'b1, 21'h1FFFFF, 21'h0FFFFF, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 32'h7FFF_FFF0};
    vecs[6]  = '{"touch_w1_clean",   1'b0, 32'h0,         1'b1, 1'b1, 1'b0, 1'b0, 1'b0,
                 1'b1, 21'h1FFFFF, 21'h0FFFFF, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 32'hFFFF_FFF0};
    vecs[7]  = '{"fill_beats_touch", 1'b0, 32'h0,         1'b1, 1'b1, 1'b1, 1'b1, 1'b0,
                 1'b1, 21'h0FFFFF, 21'h0FFFFF, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 32'h7FFF_FFF0};
    vecs[8]  = '{"lookup_set1",      1'b1, 32'h0000_0010, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0,
                 1'b1, 21'h000000, 21'h000000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0000_0010};
    vecs[9]  = '{"fill_set1",        1'b0, 32'h0,         1'b0, 1'b0, 1'b0, 1'b1, 1'b1,
                 1'b1, 21'h000000, 21'h000000, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 32'h0000_0010};
    vecs[10] = '{"back_to_7f",       1'b1, 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0,
                 1'b1, 21'h0FFFFF, 21'h0FFFFF, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 32'h7FFF_FFF0};
    vecs[11] = '{"touch_old_set",    1'b1, 32'h0000_0010, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0,
                 1'b1, 21'h000000, 21'h000000, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 32'h0000_0010};
    vecs[12] = '{"bypass_same_set",  1'b1, 32'h0000_0010, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0,
                 1'b1, 21'h000000, 21'h000000, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 32'h0000_0010};
    vecs[13] = '{"7f_after_touch",   1'b1, 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0,
                 1'b1, 21'h0FFFFF, 21'h0FFFFF, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 32'h7FFF_FFF0};
    final_vec = '{"lookup_after_rst", 1'b1, 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0,
                 1'b1, 21'h000000, 21'h000000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0000_07F0};

    doReset(1);
    checkResetState("reset1");
    runSweep("sweep1", 5);

    for (int i = 0; i < 14; i++) begin
      applyStimulus(vecs[i]);
      checkOutput(vecs[i]);
    end

    doReset(3);
    checkResetState("reset_ready");
    repeat (50) @(posedge clk);
    #1;
    checkField("mid_sweep", "init_busy", 32'(bus.init_busy), 32'h1);
    doReset(1);
    checkResetState("reset_mid_sweep");
    runSweep("sweep2", -1);

    applyStimulus(final_vec);
    checkOutput(final_vec);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
